regfile_host_bridge: RTL and testbench

Byte-stream command bridge that sits directly upstream of the flash loader's register-file port. It parses host command frames from an 8-bit valid/ready receive stream and turns them into single-cycle register-file writes or latency-compensated reads. It returns acknowledge or read-data bytes on an 8-bit valid/ready transmit stream. It is the only master of the loader's RegFile* inputs.

---
 rtl/regfile_host_bridge.sv | 233 +++++++++++++++++++++++
 tb/tb_regfile_host_bridge.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_host_bridge.sv
// Host byte-stream to flash-loader register-file bridge: write/read command frames, ACK/NAK responses.
// Optional trailing XOR checksum byte per frame when REGBRIDGE_CHECKSUM_EN is defined.
module regfile_host_bridge #(
  parameter int unsigned RD_LAT      = 2,
  parameter int unsigned TIMEOUT_CYC = 100000
) (
  input  logic        FpgaClk,
  input  logic        RST,
  input  logic [7:0]  RxData,
  input  logic        RxValid,
  output logic        RxReady,
  output logic [7:0]  TxData,
  output logic        TxValid,
  input  logic        TxReady,
  output logic [15:0] RegFileWrAddress,
  output logic [17:0] RegFileWrData,
  output logic        RegFileWrEn,
  output logic [15:0] RegFileRdAddress,
  input  logic [15:0] RegFileRdData,
  output logic        Busy
);

  localparam logic [7:0]  OP_WRITE = 8'h57;
  localparam logic [7:0]  OP_READ  = 8'h52;
  localparam logic [7:0]  RSP_ACK  = 8'h06;
  localparam logic [7:0]  RSP_NAK  = 8'h15;
  localparam logic [23:0] TO_LAST  = 24'(TIMEOUT_CYC - 1);
  localparam logic [3:0]  RD_LAST  = 4'(RD_LAT);

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_ADDR_H,
    ST_ADDR_L,
    ST_DATA2,
    ST_DATA1,
    ST_DATA0,
`ifdef REGBRIDGE_CHECKSUM_EN
    ST_CSUM,
`endif
    ST_WRITE,
    ST_RD_WAIT,
    ST_TX_HI,
    ST_TX_LO,
    ST_TX_ACK,
    ST_TX_NAK
  } state_e;

  state_e      state_q, state_d;
  logic        is_wr_q, is_wr_d;
  logic [15:0] addr_q, addr_d;
  logic [17:0] data_q, data_d;
  logic [23:0] to_cnt_q, to_cnt_d;
  logic [3:0]  rd_cnt_q, rd_cnt_d;
  logic [15:0] rd_hold_q, rd_hold_d;
  logic [15:0] wr_addr_q, wr_addr_d;
  logic [17:0] wr_data_q, wr_data_d;
  logic [15:0] rd_addr_q, rd_addr_d;
  logic        tx_valid_q, tx_valid_d;
  logic        rx_state, in_frame;
  logic        rx_fire, tx_fire, rd_done, timeout_hit;
`ifdef REGBRIDGE_CHECKSUM_EN
  logic [7:0]  csum_q, csum_d;
  logic        csum_ok;
  assign csum_ok = (RxData == csum_q);
`endif

  assign rx_fire     = RxValid & RxReady;
  assign tx_fire     = tx_valid_q & TxReady;
  assign rd_done     = (rd_cnt_q == RD_LAST);
  // An accepted byte always beats an expiring timeout in the same cycle.
  assign timeout_hit = (TIMEOUT_CYC != 0) && in_frame && !rx_fire && (to_cnt_q == TO_LAST);

  assign RegFileWrAddress = wr_addr_q;
  assign RegFileWrData    = wr_data_q;
  assign RegFileRdAddress = rd_addr_q;

  always_ff @(posedge FpgaClk) begin
    if (RST) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (timeout_hit) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE:   if (rx_fire) state_d = (RxData == OP_WRITE || RxData == OP_READ) ? ST_ADDR_H : ST_TX_NAK;
        ST_ADDR_H: if (rx_fire) state_d = ST_ADDR_L;
`ifdef REGBRIDGE_CHECKSUM_EN
        ST_ADDR_L: if (rx_fire) state_d = is_wr_q ? ST_DATA2 : ST_CSUM;
        ST_DATA2:  if (rx_fire) state_d = ST_DATA1;
        ST_DATA1:  if (rx_fire) state_d = ST_DATA0;
        ST_DATA0:  if (rx_fire) state_d = ST_CSUM;
        ST_CSUM:   if (rx_fire) state_d = !csum_ok ? ST_TX_NAK : (is_wr_q ? ST_WRITE : ST_RD_WAIT);
`else
        ST_ADDR_L: if (rx_fire) state_d = is_wr_q ? ST_DATA2 : ST_RD_WAIT;
        ST_DATA2:  if (rx_fire) state_d = ST_DATA1;
        ST_DATA1:  if (rx_fire) state_d = ST_DATA0;
        ST_DATA0:  if (rx_fire) state_d = ST_WRITE;
`endif
        ST_WRITE:   state_d = ST_TX_ACK;
        ST_RD_WAIT: if (rd_done) state_d = ST_TX_HI;
        ST_TX_HI:   if (tx_fire) state_d = ST_TX_LO;
        ST_TX_LO:   if (tx_fire) state_d = ST_IDLE;
        ST_TX_ACK:  if (tx_fire) state_d = ST_IDLE;
        ST_TX_NAK:  if (tx_fire) state_d = ST_IDLE;
        default:    state_d = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    rx_state    = 1'b0;
    in_frame    = 1'b0;
    RegFileWrEn = 1'b0;
    TxData      = '0;
    case (state_q)
      ST_IDLE: rx_state = 1'b1;
      ST_ADDR_H, ST_ADDR_L, ST_DATA2, ST_DATA1, ST_DATA0: begin
        rx_state = 1'b1;
        in_frame = 1'b1;
      end
`ifdef REGBRIDGE_CHECKSUM_EN
      ST_CSUM: begin
        rx_state = 1'b1;
        in_frame = 1'b1;
      end
`endif
      ST_WRITE:  RegFileWrEn = 1'b1;
      ST_TX_HI:  TxData = rd_hold_q[15:8];
      ST_TX_LO:  TxData = rd_hold_q[7:0];
      ST_TX_ACK: TxData = RSP_ACK;
      ST_TX_NAK: TxData = RSP_NAK;
      default: ;
    endcase
    RxReady = rx_state & ~RST;
    Busy    = (state_q != ST_IDLE);
    TxValid = tx_valid_q;
  end

  always_comb begin
    is_wr_d    = is_wr_q;
    addr_d     = addr_q;
    data_d     = data_q;
    rd_hold_d  = rd_hold_q;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    rd_addr_d  = rd_addr_q;
    tx_valid_d = tx_valid_q;
    to_cnt_d   = (in_frame && !rx_fire && !timeout_hit) ? to_cnt_q + 24'd1 : '0;
    rd_cnt_d   = (state_q == ST_RD_WAIT && !rd_done) ? rd_cnt_q + 4'd1 : '0;
`ifdef REGBRIDGE_CHECKSUM_EN
    csum_d     = (state_q == ST_IDLE) ? '0 : csum_q;
    if (rx_fire) csum_d = csum_d ^ RxData;
`endif
    case (state_q)
      ST_IDLE:   if (rx_fire) is_wr_d = (RxData == OP_WRITE);
      ST_ADDR_H: if (rx_fire) addr_d[15:8] = RxData;
      ST_ADDR_L: begin
        if (rx_fire) addr_d[7:0] = RxData;
`ifndef REGBRIDGE_CHECKSUM_EN
        if (rx_fire && !is_wr_q) rd_addr_d = {addr_q[15:8], RxData};
`endif
      end
      ST_DATA2:  if (rx_fire) data_d[17:16] = RxData[1:0];
      ST_DATA1:  if (rx_fire) data_d[15:8] = RxData;
      ST_DATA0: begin
        if (rx_fire) data_d[7:0] = RxData;
`ifndef REGBRIDGE_CHECKSUM_EN
        if (rx_fire) begin
          wr_addr_d = addr_q;
          wr_data_d = {data_q[17:8], RxData};
        end
`endif
      end
`ifdef REGBRIDGE_CHECKSUM_EN
      ST_CSUM: begin
        if (rx_fire && csum_ok && is_wr_q) begin
          wr_addr_d = addr_q;
          wr_data_d = data_q;
        end
        if (rx_fire && csum_ok && !is_wr_q) rd_addr_d = addr_q;
      end
`endif
      ST_RD_WAIT: begin
        if (rd_done) begin
          rd_hold_d  = RegFileRdData;
          tx_valid_d = 1'b1;
        end
      end
      // ACK/NAK raise TxValid one cycle after entry; TX_LO enters already valid.
      ST_TX_LO, ST_TX_ACK, ST_TX_NAK: begin
        if (!tx_valid_q)  tx_valid_d = 1'b1;
        else if (TxReady) tx_valid_d = 1'b0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge FpgaClk) begin
    if (RST) begin
      is_wr_q    <= 1'b0;
      addr_q     <= '0;
      data_q     <= '0;
      to_cnt_q   <= '0;
      rd_cnt_q   <= '0;
      rd_hold_q  <= '0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      rd_addr_q  <= '0;
      tx_valid_q <= 1'b0;
`ifdef REGBRIDGE_CHECKSUM_EN
      csum_q     <= '0;
`endif
    end else begin
      is_wr_q    <= is_wr_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      to_cnt_q   <= to_cnt_d;
      rd_cnt_q   <= rd_cnt_d;
      rd_hold_q  <= rd_hold_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      rd_addr_q  <= rd_addr_d;
      tx_valid_q <= tx_valid_d;
`ifdef REGBRIDGE_CHECKSUM_EN
      csum_q     <= csum_d;
`endif
    end
  end

endmodule

// File: tb/tb_regfile_host_bridge.sv
// Directed self-checking bench for regfile_host_bridge (RD_LAT=2, TIMEOUT_CYC=16).
// Frames get a trailing XOR checksum appended automatically when REGBRIDGE_CHECKSUM_EN is defined.
module tb_regfile_host_bridge;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic [15:0] wr_addr;
  logic [17:0] wr_data;
  logic        wr_en;
  logic [15:0] rd_addr;
  logic [15:0] rd_data;
  logic        busy;

  int checks = 0;
  int errors = 0;
  int wr_pulses = 0;
  int exp_pulses = 0;
  logic [7:0]  frame [6];
  logic [7:0]  rsp;
  logic [15:0] p1, p2;

  always #5 clk = ~clk;

  regfile_host_bridge #(.RD_LAT(2), .TIMEOUT_CYC(16)) dut (
    .FpgaClk(clk), .RST(rst),
    .RxData(rx_data), .RxValid(rx_valid), .RxReady(rx_ready),
    .TxData(tx_data), .TxValid(tx_valid), .TxReady(tx_ready),
    .RegFileWrAddress(wr_addr), .RegFileWrData(wr_data), .RegFileWrEn(wr_en),
    .RegFileRdAddress(rd_addr), .RegFileRdData(rd_data), .Busy(busy)
  );

  // Loader read port model: 2-cycle latency, data = address ^ 0xACDB (0x1234 -> 0xBEEF).
  always_ff @(posedge clk) begin
    p1 <= rd_addr ^ 16'hACDB;
    p2 <= p1;
  end
  assign rd_data = p2;

  always @(negedge clk) if (wr_en === 1'b1) wr_pulses++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge clk);
    while (!rx_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!rx_ready) check("rx_accept_wait", 32'(rx_ready), 32'd1);
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
  endtask

  task automatic send_frame(input int n, input bit full);
    logic [7:0] x = '0;
    for (int i = 0; i < n; i++) begin
      x ^= frame[i];
      send_byte(frame[i]);
    end
`ifdef REGBRIDGE_CHECKSUM_EN
    if (full) send_byte(x);
`endif
  endtask

  task automatic recv_byte(output logic [7:0] b);
    int n = 0;
    tx_ready = 1'b1;
    @(negedge clk);
    while (!tx_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("tx_wait", 32'(tx_valid), 32'd1);
    b = tx_data;
    @(posedge clk);
    #1;
    tx_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; rx_valid = 1'b0; rx_data = '0; tx_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rxready_in_rst", 32'(rx_ready), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    check("rst_rxready", 32'(rx_ready), 32'd1);
    check("rst_txvalid", 32'(tx_valid), 32'd0);
    check("rst_busy",    32'(busy),     32'd0);
    check("rst_wren",    32'(wr_en),    32'd0);
    check("rst_wraddr",  32'(wr_addr),  32'd0);
    check("rst_wrdata",  32'(wr_data),  32'd0);
    check("rst_rdaddr",  32'(rd_addr),  32'd0);

    // Write with exact strobe/ACK timing
    frame = '{8'h57, 8'h00, 8'h10, 8'h03, 8'hAB, 8'hCD};
    send_frame(6, 1'b1);
    exp_pulses++;
    check("wr_en_edgeN",   32'(wr_en),   32'd1);
    check("wr_addr",       32'(wr_addr), 32'h0010);
    check("wr_data",       32'(wr_data), 32'h3ABCD);
    check("wr_txv_edgeN",  32'(tx_valid), 32'd0);
    @(posedge clk); #1;
    check("wr_en_edgeN1",  32'(wr_en),    32'd0);
    check("wr_txv_edgeN1", 32'(tx_valid), 32'd0);
    @(posedge clk); #1;
    check("ack_valid",     32'(tx_valid), 32'd1);
    check("ack_data",      32'(tx_data),  32'h06);
    tx_ready = 1'b1;
    @(posedge clk); #1;
    tx_ready = 1'b0;
    check("ack_done_txv",  32'(tx_valid), 32'd0);
    check("ack_done_busy", 32'(busy),     32'd0);
    check("wr_addr_hold",  32'(wr_addr),  32'h0010);
    check("wr_pulses_1",   32'(wr_pulses), 32'(exp_pulses));

    // Read with latency and TxReady backpressure
    frame = '{8'h52, 8'h12, 8'h34, 8'h00, 8'h00, 8'h00};
    send_frame(3, 1'b1);
    check("rd_addr",     32'(rd_addr),  32'h1234);
    check("rd_busy",     32'(busy),     32'd1);
    repeat (2) @(posedge clk);
    #1;
    check("rd_early_txv", 32'(tx_valid), 32'd0);
    @(posedge clk); #1;
    check("rd_hi_valid", 32'(tx_valid), 32'd1);
    check("rd_hi_data",  32'(tx_data),  32'hBE);
    repeat (5) @(posedge clk);
    #1;
    check("rd_hi_hold_v", 32'(tx_valid), 32'd1);
    check("rd_hi_hold_d", 32'(tx_data),  32'hBE);
    tx_ready = 1'b1;
    @(posedge clk); #1;
    check("rd_lo_valid", 32'(tx_valid), 32'd1);
    check("rd_lo_data",  32'(tx_data),  32'hEF);
    @(posedge clk); #1;
    tx_ready = 1'b0;
    check("rd_done_txv",  32'(tx_valid), 32'd0);
    check("rd_done_busy", 32'(busy),     32'd0);

    // Bad opcode -> NAK, then a normal write
    send_byte(8'h41);
    check("nak_edgeN_txv", 32'(tx_valid), 32'd0);
    check("nak_rxready",   32'(rx_ready), 32'd0);
    @(posedge clk); #1;
    check("nak_valid",     32'(tx_valid), 32'd1);
    check("nak_data",      32'(tx_data),  32'h15);
    tx_ready = 1'b1;
    @(posedge clk); #1;
    tx_ready = 1'b0;
    check("nak_done_busy", 32'(busy),     32'd0);
    check("nak_done_rxr",  32'(rx_ready), 32'd1);
    check("nak_no_wr",     32'(wr_pulses), 32'(exp_pulses));
    frame = '{8'h57, 8'h00, 8'h20, 8'hFF, 8'h12, 8'h34};
    send_frame(6, 1'b1);
    exp_pulses++;
    recv_byte(rsp);
    check("w2_ack",    32'(rsp),     32'h06);
    check("w2_addr",   32'(wr_addr), 32'h0020);
    check("w2_data",   32'(wr_data), 32'h31234);
    check("w2_pulses", 32'(wr_pulses), 32'(exp_pulses));

    // Timeout after 16 idle cycles inside a frame
    frame = '{8'h57, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    send_frame(2, 1'b0);
    repeat (15) @(posedge clk);
    #1;
    check("to_busy_15", 32'(busy), 32'd1);
    @(posedge clk); #1;
    check("to_busy_16", 32'(busy),     32'd0);
    check("to_txv",     32'(tx_valid), 32'd0);
    check("to_no_wr",   32'(wr_pulses), 32'(exp_pulses));
    frame = '{8'h57, 8'h00, 8'h30, 8'h00, 8'h00, 8'h01};
    send_frame(6, 1'b1);
    exp_pulses++;
    recv_byte(rsp);
    check("w3_ack",  32'(rsp),     32'h06);
    check("w3_addr", 32'(wr_addr), 32'h0030);
    check("w3_data", 32'(wr_data), 32'h00001);

`ifdef REGBRIDGE_CHECKSUM_EN
    // Checksum good (0x53) and bad (0x00)
    frame = '{8'h57, 8'h00, 8'h01, 8'h00, 8'h00, 8'h05};
    send_frame(6, 1'b0);
    send_byte(8'h53);
    exp_pulses++;
    recv_byte(rsp);
    check("cs_ok_ack",  32'(rsp),     32'h06);
    check("cs_ok_addr", 32'(wr_addr), 32'h0001);
    check("cs_ok_data", 32'(wr_data), 32'h00005);
    send_frame(6, 1'b0);
    send_byte(8'h00);
    recv_byte(rsp);
    check("cs_bad_nak", 32'(rsp), 32'h15);
    check("cs_bad_no_wr", 32'(wr_pulses), 32'(exp_pulses));
    frame = '{8'h52, 8'h55, 8'h66, 8'h00, 8'h00, 8'h00};
    send_frame(3, 1'b0);
    send_byte(8'hFF);
    recv_byte(rsp);
    check("cs_rd_nak",  32'(rsp),     32'h15);
    check("cs_rd_addr", 32'(rd_addr), 32'h1234);
`endif

    // Reset one cycle after D1 is accepted
    frame = '{8'h57, 8'h00, 8'h40, 8'h01, 8'h22, 8'h33};
    send_frame(5, 1'b0);
    @(posedge clk); #1;
    rst = 1'b1; rx_valid = 1'b1; rx_data = 8'h33;
    @(negedge clk);
    check("mid_rst_rxready", 32'(rx_ready), 32'd0);
    @(posedge clk); #1;
    check("mid_rst_wren",   32'(wr_en),    32'd0);
    check("mid_rst_busy",   32'(busy),     32'd0);
    check("mid_rst_txv",    32'(tx_valid), 32'd0);
    check("mid_rst_txd",    32'(tx_data),  32'd0);
    check("mid_rst_wraddr", 32'(wr_addr),  32'd0);
    check("mid_rst_wrdata", 32'(wr_data),  32'd0);
    check("mid_rst_rdaddr", 32'(rd_addr),  32'd0);
    rst = 1'b0; rx_valid = 1'b0;
    #1;
    check("post_rst_rxready", 32'(rx_ready), 32'd1);
    repeat (4) @(posedge clk);
    #1;
    check("post_rst_no_wr", 32'(wr_pulses), 32'(exp_pulses));
    check("post_rst_busy",  32'(busy),      32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
